// File: rtl/boid_frame_sequencer.sv
// Per-frame scheduler for the boid display RAM: clears the frame, then draws a
// SPRITE_DIM x SPRITE_DIM square for every BPU in raster order.
module boid_frame_sequencer #(
  parameter int unsigned MAX_BOIDS      = 4,
  parameter int unsigned BITS_FOR_BOIDS = $clog2(MAX_BOIDS),
  parameter int unsigned SPRITE_DIM     = 2,
  parameter int unsigned VIDEO_WIDTH    = 640,
  parameter int unsigned VIDEO_HEIGHT   = 480,
  parameter int unsigned ADDR_WIDTH     = 19
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      frame_end,
  input  logic [9:0]                boid_x,
  input  logic [8:0]                boid_y,
  output logic [BITS_FOR_BOIDS-1:0] boid_sel,
  output logic                      fb_clear,
  output logic                      fb_we,
  output logic [ADDR_WIDTH-1:0]     fb_addr,
  output logic                      busy,
  output logic [15:0]               frame_count,
  output logic [7:0]                overrun_count
);

  localparam int unsigned DimW = (SPRITE_DIM > 1) ? $clog2(SPRITE_DIM) : 1;
  localparam logic [DimW-1:0] DimLast = DimW'(SPRITE_DIM - 1);
  localparam logic [BITS_FOR_BOIDS-1:0] SelLast = BITS_FOR_BOIDS'(MAX_BOIDS - 1);
  localparam logic [10:0] WidthLim = 11'(VIDEO_WIDTH);
  localparam logic [9:0] HeightLim = 10'(VIDEO_HEIGHT);

  typedef enum logic [2:0] {StIdle, StClear, StFetch, StDraw, StDone} state_e;

  state_e                    state_q, state_d;
  logic [BITS_FOR_BOIDS-1:0] sel_q, sel_d;
  logic                      clear_q, clear_d;
  logic                      we_q, we_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic                      busy_q, busy_d;
  logic [15:0]               frames_q, frames_d;
  logic [7:0]                overruns_q, overruns_d;
  logic [9:0]                x_q, x_d;
  logic [8:0]                y_q, y_d;
  logic [DimW-1:0]           dx_q, dx_d, dy_q, dy_d;

  logic [10:0]           px;
  logic [9:0]            py;
  logic [ADDR_WIDTH-1:0] lin_addr;

  always_comb begin
    px       = {1'b0, x_q} + 11'(dx_q);
    py       = {1'b0, y_q} + 10'(dy_q);
    lin_addr = ADDR_WIDTH'(py) * ADDR_WIDTH'(VIDEO_WIDTH) + ADDR_WIDTH'(px);
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    clear_d    = 1'b0;
    we_d       = 1'b0;
    addr_d     = addr_q;
    frames_d   = frames_q;
    overruns_d = overruns_q;
    x_d        = x_q;
    y_d        = y_q;
    dx_d       = dx_q;
    dy_d       = dy_q;

    // Pulses arriving mid-sequence are dropped, only counted.
    if (frame_end && (state_q != StIdle) && (overruns_q != 8'hFF)) begin
      overruns_d = overruns_q + 8'd1;
    end

    case (state_q)
      StIdle: begin
        if (frame_end) begin
          state_d = StClear;
          clear_d = 1'b1;
          sel_d   = '0;
        end
      end
      StClear: state_d = StFetch;
      StFetch: begin
        x_d     = boid_x;
        y_d     = boid_y;
        dx_d    = '0;
        dy_d    = '0;
        state_d = StDraw;
      end
      StDraw: begin
        if ((px < WidthLim) && (py < HeightLim)) begin
          we_d   = 1'b1;
          addr_d = lin_addr;
        end
        if (dx_q == DimLast) begin
          dx_d = '0;
          if (dy_q == DimLast) begin
            dy_d = '0;
            if (sel_q == SelLast) begin
              sel_d   = '0;
              state_d = StDone;
            end else begin
              sel_d   = sel_q + BITS_FOR_BOIDS'(1);
              state_d = StFetch;
            end
          end else begin
            dy_d = dy_q + DimW'(1);
          end
        end else begin
          dx_d = dx_q + DimW'(1);
        end
      end
      StDone: begin
        frames_d = frames_q + 16'd1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      clear_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      frames_q   <= '0;
      overruns_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      clear_q    <= clear_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      frames_q   <= frames_d;
      overruns_q <= overruns_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
    end
  end

  assign boid_sel      = sel_q;
  assign fb_clear      = clear_q;
  assign fb_we         = we_q;
  assign fb_addr       = addr_q;
  assign busy          = busy_q;
  assign frame_count   = frames_q;
  assign overrun_count = overruns_q;

endmodule

// File: tb/tb_boid_frame_sequencer.sv
// Bench for boid_frame_sequencer: table vectors, random frames against a cycle-indexed
// expectation model, reset abort, SPRITE_DIM=1 instance and overrun saturation.
module tb_boid_frame_sequencer;
  localparam int N = 4;
  localparam int D = 2;
  localparam int L = 2 + N * (1 + D * D);

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn, frame_end, frame_end2;
  logic [9:0]  boid_x, boid_x2;
  logic [8:0]  boid_y, boid_y2;
  logic [1:0]  boid_sel, boid_sel2;
  logic        fb_clear, fb_we, busy, fb_clear2, fb_we2, busy2;
  logic [18:0] fb_addr, fb_addr2;
  logic [15:0] frame_count, frame_count2;
  logic [7:0]  overrun_count, overrun_count2;

  int bx[N], by[N], bx2[N], by2[N];
  assign boid_x  = 10'(bx[boid_sel]);
  assign boid_y  = 9'(by[boid_sel]);
  assign boid_x2 = 10'(bx2[boid_sel2]);
  assign boid_y2 = 9'(by2[boid_sel2]);

  boid_frame_sequencer dut (
    .clock(clock), .resetn(resetn), .frame_end(frame_end), .boid_x(boid_x), .boid_y(boid_y),
    .boid_sel(boid_sel), .fb_clear(fb_clear), .fb_we(fb_we), .fb_addr(fb_addr), .busy(busy),
    .frame_count(frame_count), .overrun_count(overrun_count)
  );

  boid_frame_sequencer #(.SPRITE_DIM(1)) dut1 (
    .clock(clock), .resetn(resetn), .frame_end(frame_end2), .boid_x(boid_x2), .boid_y(boid_y2),
    .boid_sel(boid_sel2), .fb_clear(fb_clear2), .fb_we(fb_we2), .fb_addr(fb_addr2),
    .busy(busy2), .frame_count(frame_count2), .overrun_count(overrun_count2)
  );

  typedef struct packed {
    logic [3:0][9:0] x;
    logic [3:0][8:0] y;
    logic [4:0]      ov_a;
    logic [4:0]      ov_b;
    logic [4:0]      n_wr;
    logic [18:0]     first;
  } vec_t;

  int total = 0;
  int bad = 0;
  int fc_exp = 0;
  int ov_exp = 0;
  int last_addr = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected per-cycle behaviour: cycle 1 clears, each boid takes one fetch cycle plus
  // D*D draw cycles, and each drawn slot shows up as a write one cycle later.
  task automatic run_frame(input int ov_a, input int ov_b, output int nwr, output int first);
    bit ew[64];
    int ea[64];
    int n_ov;
    for (int c = 0; c < 64; c++) begin
      ew[c] = 0;
      ea[c] = 0;
    end
    for (int b = 0; b < N; b++) begin
      for (int k = 0; k < D * D; k++) begin
        int px, py, c;
        px = bx[b] + k % D;
        py = by[b] + k / D;
        c  = 4 + b * (1 + D * D) + k;
        if (px < 640 && py < 480) begin
          ew[c] = 1;
          ea[c] = py * 640 + px;
        end
      end
    end
    nwr = 0;
    first = -1;
    @(negedge clock) frame_end = 1'b1;
    for (int c = 1; c <= L + 1; c++) begin
      @(negedge clock);
      frame_end = (c == ov_a) || (c == ov_b);
      check("busy", int'(busy), int'(c <= L));
      check("fb_clear", int'(fb_clear), int'(c == 1));
      check("fb_we", int'(fb_we), int'(ew[c]));
      if (ew[c]) last_addr = ea[c];
      check("fb_addr", int'(fb_addr), last_addr);
      if (fb_we) begin
        nwr++;
        if (first < 0) first = int'(fb_addr);
      end
    end
    frame_end = 1'b0;
    n_ov = 0;
    if (ov_a >= 1 && ov_a <= L) n_ov++;
    if (ov_b >= 1 && ov_b <= L && ov_b != ov_a) n_ov++;
    ov_exp = (ov_exp + n_ov > 255) ? 255 : ov_exp + n_ov;
    fc_exp = (fc_exp + 1) & 16'hFFFF;
    check("frame_count", int'(frame_count), fc_exp);
    check("overrun_count", int'(overrun_count), ov_exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    int nwr, first, cnt, bcnt;
    int q[$];

    vecs[0] = '{x: {10'd100, 10'd100, 10'd100, 10'd100}, y: {9'd50, 9'd50, 9'd50, 9'd50},
                ov_a: 5'd0, ov_b: 5'd0, n_wr: 5'd16, first: 19'd32100};
    vecs[1] = '{x: {10'd100, 10'd639, 10'd100, 10'd100}, y: {9'd50, 9'd479, 9'd50, 9'd50},
                ov_a: 5'd0, ov_b: 5'd0, n_wr: 5'd13, first: 19'd32100};
    vecs[2] = '{x: {10'd100, 10'd100, 10'd100, 10'd100}, y: {9'd50, 9'd50, 9'd50, 9'd50},
                ov_a: 5'd5, ov_b: 5'd21, n_wr: 5'd16, first: 19'd32100};
    vecs[3] = '{x: {10'd639, 10'd639, 10'd639, 10'd639}, y: {9'd479, 9'd479, 9'd479, 9'd479},
                ov_a: 5'd0, ov_b: 5'd0, n_wr: 5'd4, first: 19'd307199};
    vecs[4] = '{x: {10'd5, 10'd0, 10'd638, 10'd0}, y: {9'd479, 9'd478, 9'd0, 9'd0},
                ov_a: 5'd0, ov_b: 5'd0, n_wr: 5'd14, first: 19'd0};
    vecs[5] = '{x: {10'd100, 10'd100, 10'd100, 10'd100}, y: {9'd50, 9'd50, 9'd50, 9'd50},
                ov_a: 5'd22, ov_b: 5'd0, n_wr: 5'd16, first: 19'd32100};

    for (int b = 0; b < N; b++) begin
      bx[b] = 0; by[b] = 0; bx2[b] = 0; by2[b] = 0;
    end
    resetn = 1'b0;
    frame_end = 1'b0;
    frame_end2 = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_fb_we", int'(fb_we), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fb_clear", int'(fb_clear), 0);
    check("rst_boid_sel", int'(boid_sel), 0);
    check("rst_fb_addr", int'(fb_addr), 0);
    check("rst_frame_count", int'(frame_count), 0);
    check("rst_overrun_count", int'(overrun_count), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      for (int b = 0; b < N; b++) begin
        bx[b] = int'(vecs[i].x[b]);
        by[b] = int'(vecs[i].y[b]);
      end
      run_frame(int'(vecs[i].ov_a), int'(vecs[i].ov_b), nwr, first);
      check($sformatf("vec%0d_writes", i), nwr, int'(vecs[i].n_wr));
      check($sformatf("vec%0d_first_addr", i), first, int'(vecs[i].first));
    end

    for (int i = 0; i < 20; i++) begin
      int oa, ob;
      for (int b = 0; b < N; b++) begin
        bx[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(636, 639))
                                             : int'($urandom_range(0, 639));
        by[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(476, 479))
                                             : int'($urandom_range(0, 479));
      end
      oa = int'($urandom_range(0, L));
      ob = int'($urandom_range(0, L));
      if (ob == oa) ob = 0;
      run_frame(oa, ob, nwr, first);
    end

    // Reset while boid 1 is drawing.
    for (int b = 0; b < N; b++) begin
      bx[b] = 100; by[b] = 50;
    end
    @(negedge clock) frame_end = 1'b1;
    @(negedge clock) frame_end = 1'b0;
    repeat (8) @(negedge clock);
    check("pre_reset_fb_we", int'(fb_we), 1);
    check("pre_reset_boid_sel", int'(boid_sel), 1);
    resetn = 1'b0;
    #1;
    check("abort_fb_we", int'(fb_we), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_boid_sel", int'(boid_sel), 0);
    check("abort_frame_count", int'(frame_count), 0);
    fc_exp = 0;
    ov_exp = 0;
    last_addr = 0;
    @(negedge clock) resetn = 1'b1;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (fb_we || busy) cnt++;
    end
    check("post_abort_activity", cnt, 0);
    run_frame(0, 0, nwr, first);
    check("post_abort_writes", nwr, 16);

    // SPRITE_DIM=1 instance.
    bx2[0] = 0; by2[0] = 0; bx2[1] = 1; by2[1] = 0;
    bx2[2] = 0; by2[2] = 1; bx2[3] = 10; by2[3] = 10;
    @(negedge clock) frame_end2 = 1'b1;
    bcnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      frame_end2 = 1'b0;
      if (c == 1) check("dim1_fb_clear", int'(fb_clear2), 1);
      if (busy2) bcnt++;
      if (fb_we2) q.push_back(int'(fb_addr2));
    end
    check("dim1_busy_cycles", bcnt, 10);
    check("dim1_write_count", q.size(), 4);
    while (q.size() < 4) q.push_back(-1);
    check("dim1_addr0", q[0], 0);
    check("dim1_addr1", q[1], 1);
    check("dim1_addr2", q[2], 640);
    check("dim1_addr3", q[3], 6410);
    check("dim1_frame_count", int'(frame_count2), 1);

    // frame_end held high: each 23 cycles start one frame and add 22 overruns.
    @(negedge clock) frame_end = 1'b1;
    repeat (14 * 23) @(negedge clock);
    frame_end = 1'b0;
    repeat (30) @(negedge clock);
    check("sat_overrun_count", int'(overrun_count), 255);
    check("sat_frame_count", int'(frame_count), fc_exp + 14);
    check("sat_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/boid_frame_sequencer.md
Name: boid_frame_sequencer

Overview:
- Per-frame scheduler for the boid display RAM.
- On each end-of-frame pulse from the VGA controller it issues a one-cycle clear to the display RAM. It then steps through every BPU, reads each boid's pixel location and writes a SPRITE_DIM x SPRITE_DIM square of set pixels into the RAM.
- It replaces the ad-hoc counter in the top level. It owns the BPU read-select and the display RAM write port.

Parameters:
- MAX_BOIDS, 4, number of BPUs sequenced per frame (power of 2, >=2).
- BITS_FOR_BOIDS, $clog2(MAX_BOIDS), width of the boid select.
- SPRITE_DIM, 2, edge length in pixels of each drawn boid (1..4).
- VIDEO_WIDTH, 640, screen width in pixels.
- VIDEO_HEIGHT, 480, screen height in pixels.
- ADDR_WIDTH, 19, display RAM address width.

Ports:
- clock  in  1  system clock (50 MHz domain).
- resetn  in  1  asynchronous, active-low reset.
- frame_end  in  1  one-cycle end-of-frame pulse (screenEnd_out), synchronous to clock.
- boid_x  in  10  x location of the boid selected by boid_sel, valid combinationally.
- boid_y  in  9  y location of the boid selected by boid_sel, valid combinationally.
- boid_sel  out  BITS_FOR_BOIDS  index of the BPU whose location is being read.
- fb_clear  out  1  one-cycle clear/switch pulse to the display RAM.
- fb_we  out  1  display RAM write enable; write data is fixed at 1.
- fb_addr  out  ADDR_WIDTH  display RAM write address, y*VIDEO_WIDTH + x.
- busy  out  1  high from the cycle after an accepted frame_end until the sequence completes.
- frame_count  out  16  number of completed frame sequences.
- overrun_count  out  8  number of frame_end pulses ignored while busy.

Behaviour:
- Reset (resetn low, asynchronous):
  - state = IDLE.
  - boid_sel, fb_clear, fb_we, fb_addr, busy, frame_count and overrun_count all 0.
  - Internal dx, dy, latched x/y all 0.
  - Reset asserted mid-sequence aborts the sequence; no further fb_we occurs until the next accepted frame_end.
- Registers: all outputs are registered and Moore-decoded from registered state and datapath.
- States: IDLE, CLEAR, FETCH, DRAW, DONE.
- IDLE: frame_end=1 -> CLEAR. Otherwise stay.
- CLEAR (1 cycle):
  - fb_clear=1, busy=1, boid_sel=0.
  - -> FETCH.
- FETCH (1 cycle):
  - Latch boid_x/boid_y for the current boid_sel; dx=dy=0.
  - -> DRAW.
- DRAW (SPRITE_DIM^2 cycles per boid):
  - Each cycle computes px = xl + dx (11-bit) and py = yl + dy (10-bit).
  - If px < VIDEO_WIDTH and py < VIDEO_HEIGHT: in the next cycle fb_we=1 and fb_addr = py*VIDEO_WIDTH + px, truncated to ADDR_WIDTH.
  - Otherwise that slot is clipped: fb_we=0 next cycle and the sequence still advances.
  - dx increments first; on wrap dx=0 and dy increments (raster order).
  - After the last (dx,dy):
    - if boid_sel == MAX_BOIDS-1 -> DONE;
    - else boid_sel++ -> FETCH.
- DONE (1 cycle):
  - The final fb_we (if not clipped) is visible this cycle.
  - frame_count++ (wraps at 16 bits); busy=0 next cycle.
  - boid_sel=0.
  - -> IDLE.
- fb_we: low in every cycle not immediately following a DRAW cycle. fb_addr holds its last value when fb_we=0.
- Latency: the sequence occupies exactly 1 + MAX_BOIDS*(1+SPRITE_DIM^2) + 1 cycles from the accepted frame_end edge until the return to IDLE. For defaults (4 boids, 2x2): 22 cycles.
- frame_end in any state other than IDLE:
  - ignored, with no restart and no queuing;
  - overrun_count++, saturating at 255.
- frame_end in the same cycle that DONE returns to IDLE counts as an overrun, because the state is still DONE.
- boid_sel changes only on the FETCH entry edge, so BPU mux outputs have at least 1 full cycle to settle before latching.
- Overlapping sprites or duplicate coordinates: writes are issued regardless of overlap (the RAM is write-1 idempotent).

Test Plan:
- Reset, then frame_end pulse with all boids at (100,50), defaults:
  - fb_clear high exactly 1 cycle, 1 cycle after the pulse;
  - 16 fb_we cycles, each boid at addrs 32100, 32101, 32740, 32741;
  - busy high 22 cycles; frame_count=1.
- Boid 2 at (639,479), SPRITE_DIM=2:
  - only addr 479*640+639 = 307199 written for boid 2;
  - 3 clipped slots show fb_we=0;
  - total fb_we count 13; cycle count unchanged.
- frame_end pulses at cycles +5 and +21 after an accepted pulse -> both ignored, overrun_count=2, frame_count=1. A pulse after busy falls starts a new frame: fb_clear fires and frame_count=2.
- Assert resetn low during DRAW of boid 1:
  - fb_we, busy and boid_sel drop to 0 asynchronously;
  - frame_count=0;
  - no writes until the next frame_end.
- SPRITE_DIM=1, MAX_BOIDS=4, boids at (0,0),(1,0),(0,1),(10,10) -> fb_addr sequence 0, 1, 640, 6410; sequence length 10 cycles.
- Issue 65536 frames -> frame_count wraps to 0. Force 300 overruns -> overrun_count saturates at 255.
